// File: rtl/izh_pkg.sv
// Shared constants and types for the Izhikevich parameter path.
// Holds the frame byte layout, reset defaults and the loader state encoding.
// Defaults are shared with the neuron testbench so both agree on power-up values.
package izh_pkg;

  localparam int PARAM_W = 6;
  localparam int BYTE_W  = 8;

  // First byte of every parameter frame.
  localparam logic [BYTE_W-1:0] HEADER = 8'hA5;

  // Parameter values presented to the neuron after reset.
  localparam logic [PARAM_W-1:0] DEF_A = 6'd2;
  localparam logic [PARAM_W-1:0] DEF_B = 6'd13;
  localparam logic [PARAM_W-1:0] DEF_C = 6'd0;
  localparam logic [PARAM_W-1:0] DEF_D = 6'd16;

  // Longest idle gap tolerated between bytes of one frame (timeout build only).
  localparam int TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_C,
    ST_GET_D,
    ST_GET_SUM,
    ST_COMMIT
  } loader_state_e;

  // True while a frame is partially received.
  function automatic logic in_frame(loader_state_e s);
    return (s == ST_GET_A) || (s == ST_GET_B) || (s == ST_GET_C) ||
           (s == ST_GET_D) || (s == ST_GET_SUM);
  endfunction

endpackage

// File: rtl/izh_frame_checksum.sv
// Running XOR checksum over the payload bytes of a parameter frame.
// Latency: accumulate takes effect on the next edge; compare is combinational.
// No backpressure: the caller strobes clear/accumulate only on accepted bytes.
module izh_frame_checksum
  import izh_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              acc_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic [BYTE_W-1:0] cmp_byte_i,
  output logic              match_o
);

  logic [BYTE_W-1:0] sum_q;

  // Clear wins over accumulate so a new header always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (acc_i) begin
      sum_q <= sum_q ^ byte_i;
    end
  end

  assign match_o = (sum_q == cmp_byte_i);

endmodule

// File: rtl/izh_param_loader.sv
// Byte-serial loader committing checksummed a/b/c/d frames to the neuron core.
// Latency: params and commit_pulse update one edge after the checksum byte is taken.
// Backpressure: load_ready drops only during the one-cycle COMMIT state.
// Optional inter-byte timeout enabled by defining IZH_LOADER_TIMEOUT_EN.
module izh_param_loader
  import izh_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  input  logic [BYTE_W-1:0]  load_data,
  output logic               load_ready,
  output logic [PARAM_W-1:0] param_a,
  output logic [PARAM_W-1:0] param_b,
  output logic [PARAM_W-1:0] param_c,
  output logic [PARAM_W-1:0] param_d,
  output logic               params_ready,
  output logic               commit_pulse,
  output logic               load_err,
  output logic [7:0]         param_gen
);

  loader_state_e state_q, state_d;

  logic accept;
  logic hdr_hit;
  logic cks_acc;
  logic cks_match;
  logic match_q;
  logic timeout;
  logic committing;

  logic [PARAM_W-1:0] shd_a_q, shd_b_q, shd_c_q, shd_d_q;
  logic [PARAM_W-1:0] par_a_q, par_b_q, par_c_q, par_d_q;
  logic               params_ready_q;
  logic               commit_pulse_q;
  logic               load_err_q;
  logic [7:0]         gen_q;

  assign load_ready = (state_q != ST_COMMIT);
  assign accept     = load_valid && load_ready;
  assign hdr_hit    = (state_q == ST_IDLE) && accept && (load_data == HEADER);
  assign cks_acc    = accept && ((state_q == ST_GET_A) || (state_q == ST_GET_B) ||
                                 (state_q == ST_GET_C) || (state_q == ST_GET_D));
  assign committing = (state_q == ST_COMMIT);

`ifdef IZH_LOADER_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_q, gap_d;

  // Count idle cycles inside a frame; any accepted byte restarts the count.
  always_comb begin
    gap_d = '0;
    if (in_frame(state_q) && !accept) begin
      gap_d = gap_q + 1'b1;
    end
  end

  // The limit is reached on the edge where the count would hit TIMEOUT_CYCLES.
  assign timeout = in_frame(state_q) && !accept &&
                   (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

  // Gap counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // Frame sequencing: one state per byte, then a single commit cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (hdr_hit) state_d = ST_GET_A;
      ST_GET_A:   if (accept)  state_d = ST_GET_B;
      ST_GET_B:   if (accept)  state_d = ST_GET_C;
      ST_GET_C:   if (accept)  state_d = ST_GET_D;
      ST_GET_D:   if (accept)  state_d = ST_GET_SUM;
      ST_GET_SUM: if (accept)  state_d = ST_COMMIT;
      ST_COMMIT:               state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
    if (timeout) begin
      state_d = ST_IDLE;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  izh_frame_checksum u_cks (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (hdr_hit),
    .acc_i      (cks_acc),
    .byte_i     (load_data),
    .cmp_byte_i (load_data),
    .match_o    (cks_match)
  );

  // Shadow capture of payload bytes; a timed-out frame is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_a_q <= '0;
      shd_b_q <= '0;
      shd_c_q <= '0;
      shd_d_q <= '0;
      match_q <= 1'b0;
    end else if (timeout) begin
      shd_a_q <= '0;
      shd_b_q <= '0;
      shd_c_q <= '0;
      shd_d_q <= '0;
    end else if (accept) begin
      if (state_q == ST_GET_A)   shd_a_q <= load_data[PARAM_W-1:0];
      if (state_q == ST_GET_B)   shd_b_q <= load_data[PARAM_W-1:0];
      if (state_q == ST_GET_C)   shd_c_q <= load_data[PARAM_W-1:0];
      if (state_q == ST_GET_D)   shd_d_q <= load_data[PARAM_W-1:0];
      if (state_q == ST_GET_SUM) match_q <= cks_match;
    end
  end

  // Atomic commit of all four parameters plus status on a checksum match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_a_q        <= DEF_A;
      par_b_q        <= DEF_B;
      par_c_q        <= DEF_C;
      par_d_q        <= DEF_D;
      params_ready_q <= 1'b0;
      commit_pulse_q <= 1'b0;
      load_err_q     <= 1'b0;
      gen_q          <= '0;
    end else begin
      commit_pulse_q <= committing && match_q;
      if (committing && match_q) begin
        par_a_q        <= shd_a_q;
        par_b_q        <= shd_b_q;
        par_c_q        <= shd_c_q;
        par_d_q        <= shd_d_q;
        params_ready_q <= 1'b1;
        gen_q          <= gen_q + 8'd1;
      end
      if (hdr_hit) begin
        load_err_q <= 1'b0;
      end else if ((committing && !match_q) || timeout) begin
        load_err_q <= 1'b1;
      end
    end
  end

  assign param_a      = par_a_q;
  assign param_b      = par_b_q;
  assign param_c      = par_c_q;
  assign param_d      = par_d_q;
  assign params_ready = params_ready_q;
  assign commit_pulse = commit_pulse_q;
  assign load_err     = load_err_q;
  assign param_gen    = gen_q;

endmodule

// File: doc/izh_param_loader.md
Name: izh_param_loader

Overview:
- Upstream configuration stage for the Izhikevich neuron core.
- Receives a byte-serial, checksummed parameter frame over a valid/ready byte bus.
- Commits the 6-bit a/b/c/d parameters atomically to registered outputs and raises params_ready, which gates the neuron's update.
- Sticky error, commit-pulse and generation-count status go to the host/debug path.

Parameters:
- HEADER, 8'hA5, frame start byte.
- DEF_A, 6'd2, param_a value after reset.
- DEF_B, 6'd13, param_b value after reset.
- DEF_C, 6'd0, param_c value after reset.
- DEF_D, 6'd16, param_d value after reset.
- TIMEOUT_CYCLES, 255, maximum idle gap between bytes inside a frame; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  host byte valid
- load_data  in  8  host byte
- load_ready  out  1  loader can accept a byte
- param_a  out  6  committed a
- param_b  out  6  committed b
- param_c  out  6  committed c
- param_d  out  6  committed d
- params_ready  out  1  at least one frame committed since reset
- commit_pulse  out  1  one-cycle strobe on each commit
- load_err  out  1  sticky frame error
- param_gen  out  8  commit counter

Behaviour:
- Clock and reset
  - Single clk domain.
  - rst_n low asynchronously forces: state IDLE; param_a..d = DEF_A..DEF_D; params_ready=0; commit_pulse=0; load_err=0; param_gen=0; shadow registers and checksum cleared.
  - load_ready is combinational from state.
- Handshake
  - A byte is accepted on a rising edge where load_valid && load_ready.
  - load_ready=1 in every state except COMMIT.
  - The host may hold load_valid and load_data indefinitely; there is no drop while load_ready=0.
- Frame format: HEADER, A, B, C, D, SUM.
  - SUM = A^B^C^D over full 8-bit bytes.
  - Parameter value = byte[5:0]; bits [7:6] are ignored for value but included in SUM.
- States: IDLE, GET_A, GET_B, GET_C, GET_D, GET_SUM, COMMIT.
  - IDLE: accepted byte == HEADER -> GET_A, clear running checksum, clear load_err. Any other byte is discarded, state stays IDLE, no flag.
  - GET_A..GET_D: accepted byte stored in the shadow register and XORed into the checksum; advance to the next state.
  - A HEADER value received inside a frame is treated as data; there is no resync.
  - GET_SUM: accepted byte compared with the checksum; the match result is registered; state -> COMMIT.
  - COMMIT: lasts exactly one cycle, then -> IDLE.
    - On match: outputs a..d <= shadow; params_ready <= 1; param_gen <= param_gen+1 (wraps 255->0); commit_pulse=1 for the following cycle only.
    - On mismatch: outputs unchanged; load_err <= 1.
- Latency: checksum byte accepted on edge N; new params and commit_pulse visible after edge N+1.
  - Back-to-back frames: the next HEADER can be accepted at edge N+2 at the earliest.
- Stability and counters
  - Parameter outputs never change except on a successful commit or reset.
  - params_ready never falls except on reset.
  - commit_pulse and load_err set in the same cycle is impossible; they are mutually exclusive per frame.
- Reset mid-frame: the partial frame is lost and outputs revert to defaults.

Optional Feature:
- Macro: IZH_LOADER_TIMEOUT_EN.
- Defined:
  - A gap counter of width $clog2(TIMEOUT_CYCLES+1) clears on each accepted byte and on entry to GET_A.
  - It increments each cycle in GET_A..GET_SUM with no accepted byte.
  - When it reaches TIMEOUT_CYCLES: state -> IDLE, load_err <= 1, shadow registers discarded, outputs unchanged.
  - A byte accepted in the same cycle the limit is reached takes priority; no timeout occurs.
- Undefined: no counter is present and the frame waits forever; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package izh_pkg holds:
  - PARAM_W=6, BYTE_W=8, HEADER constant.
  - Default parameter constants, shared with the neuron testbench.
  - Loader state enum typedef.
- Natural sub-module: izh_frame_checksum, a running XOR accumulator with clear/accumulate/compare ports.
- The FSM and output registers stay in izh_param_loader.

Test Plan:
- Reset release with no traffic -> a/b/c/d = 2/13/0/16, params_ready=0, load_ready=1, param_gen=0.
- Frame A5 02 19 20 08 33 with valid held continuously:
  - -> a=2, b=25, c=32, d=8 two edges after the 0x33 byte.
  - -> commit_pulse high one cycle, params_ready=1, param_gen=1, load_ready=0 during the COMMIT cycle.
- Same frame with SUM=0x34 -> outputs stay 2/13/0/16, load_err=1, param_gen=0.
  - A subsequent good frame's header clears load_err and commits normally.
- Garbage 11 A4 00 before a valid frame, and an FF byte as the A byte -> garbage ignored in IDLE; the FF frame with SUM including 0xFF commits a=63.
- 256 good frames -> param_gen wraps to 0, params_ready stays 1.
- rst_n asserted asynchronously after the C byte -> outputs return to defaults immediately.
  - With IZH_LOADER_TIMEOUT_EN: stall 255 cycles after the B byte -> IDLE, load_err=1.
  - With IZH_LOADER_TIMEOUT_EN: stall 254 cycles then the byte arrives -> frame continues.
